// File: rtl/toggle_reg_alu_if.sv
// Bundle between the toggle controller / switch bus and the capture ALU,
// including the result, flag and field-indicator outputs.
interface toggle_reg_alu_if #(
    parameter int WIDTH = 4
);
    logic             Load;
    logic [WIDTH-1:0] Din;
    logic [WIDTH-1:0] Result;
    logic             Carry;
    logic             Zero;
    logic             Valid;
    logic             Led_a;
    logic             Led_b;
    logic             Led_op;

    modport master (
        output Load, Din,
        input  Result, Carry, Zero, Valid, Led_a, Led_b, Led_op
    );

    modport slave (
        input  Load, Din,
        output Result, Carry, Zero, Valid, Led_a, Led_b, Led_op
    );
endinterface

// File: rtl/toggle_reg_alu.sv
// Captures A, B and opcode on successive Load rising edges, then runs one
// registered ALU cycle and holds the result/flags until the next sequence.
module toggle_reg_alu #(
    parameter int WIDTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    toggle_reg_alu_if.slave   bus
);

    typedef enum logic [4:0] {
        W_A  = 5'b00001,
        W_B  = 5'b00010,
        W_OP = 5'b00100,
        EXEC = 5'b01000,
        TRAP = 5'b10000
    } state_t;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_NOT = 3'b101;
    localparam logic [2:0] OP_SHL = 3'b110;
    localparam logic [2:0] OP_SHR = 3'b111;

    state_t           state_reg;
    logic             load_d_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [2:0]       op_reg;
    logic [WIDTH-1:0] result_reg;
    logic             carry_reg;
    logic             zero_reg;
    logic             valid_reg;
    logic             led_a_reg;
    logic             led_b_reg;
    logic             led_op_reg;

    logic             ld;
    logic [WIDTH:0]   alu_next;
    logic [WIDTH-1:0] and_v;
    logic [WIDTH-1:0] or_v;
    logic [WIDTH-1:0] xor_v;
    logic [WIDTH-1:0] not_v;

    // A held Load yields a single event: it must drop for a cycle to re-arm.
    assign ld = bus.Load & ~load_d_reg;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_lane
            assign and_v[gi] = a_reg[gi] & b_reg[gi];
            assign or_v[gi]  = a_reg[gi] | b_reg[gi];
            assign xor_v[gi] = a_reg[gi] ^ b_reg[gi];
            assign not_v[gi] = ~a_reg[gi];
        end
    endgenerate

    // Bit WIDTH carries the carry, borrow or shifted-out bit.
    always_comb begin
        alu_next = '0;
        case (op_reg)
            OP_ADD:  alu_next = {1'b0, a_reg} + {1'b0, b_reg};
            OP_SUB:  alu_next = {1'b0, a_reg} - {1'b0, b_reg};
            OP_AND:  alu_next = {1'b0, and_v};
            OP_OR:   alu_next = {1'b0, or_v};
            OP_XOR:  alu_next = {1'b0, xor_v};
            OP_NOT:  alu_next = {1'b0, not_v};
            OP_SHL:  alu_next = {a_reg, 1'b0};
            OP_SHR:  alu_next = {a_reg[0], 1'b0, a_reg[WIDTH-1:1]};
            default: alu_next = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= W_A;
            load_d_reg <= 1'b0;
            a_reg      <= '0;
            b_reg      <= '0;
            op_reg     <= '0;
            result_reg <= '0;
            carry_reg  <= 1'b0;
            zero_reg   <= 1'b0;
            valid_reg  <= 1'b0;
            led_a_reg  <= 1'b1;
            led_b_reg  <= 1'b0;
            led_op_reg <= 1'b0;
        end else begin
            load_d_reg <= bus.Load;
            case (state_reg)
                W_A: if (ld) begin
                    a_reg     <= bus.Din;
                    valid_reg <= 1'b0;
                    led_a_reg <= 1'b0;
                    led_b_reg <= 1'b1;
                    state_reg <= W_B;
                end
                W_B: if (ld) begin
                    b_reg      <= bus.Din;
                    led_b_reg  <= 1'b0;
                    led_op_reg <= 1'b1;
                    state_reg  <= W_OP;
                end
                W_OP: if (ld) begin
                    op_reg     <= bus.Din[2:0];
                    led_op_reg <= 1'b0;
                    led_a_reg  <= 1'b1;
                    state_reg  <= EXEC;
                end
                EXEC: begin
                    result_reg <= alu_next[WIDTH-1:0];
                    carry_reg  <= alu_next[WIDTH];
                    zero_reg   <= (alu_next[WIDTH-1:0] == '0);
                    valid_reg  <= 1'b1;
                    state_reg  <= W_A;
                end
                default: begin
                    // Trap or corrupted encoding: recover exactly as from reset.
                    state_reg  <= W_A;
                    a_reg      <= '0;
                    b_reg      <= '0;
                    op_reg     <= '0;
                    result_reg <= '0;
                    carry_reg  <= 1'b0;
                    zero_reg   <= 1'b0;
                    valid_reg  <= 1'b0;
                    led_a_reg  <= 1'b1;
                    led_b_reg  <= 1'b0;
                    led_op_reg <= 1'b0;
                end
            endcase
        end
    end

    assign bus.Result = result_reg;
    assign bus.Carry  = carry_reg;
    assign bus.Zero   = zero_reg;
    assign bus.Valid  = valid_reg;
    assign bus.Led_a  = led_a_reg;
    assign bus.Led_b  = led_b_reg;
    assign bus.Led_op = led_op_reg;

endmodule
